// File: rtl/playback_ctrl_pkg.sv
// Shared state encoding for the playback sequencer.
package playback_pkg;
    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_PLAY    = 2'd2
    } state_t;
endpackage

// File: rtl/playback_ctrl_if.sv
// FIFO / DAC / host-side signal bundle of the playback sequencer.
interface playback_ctrl_if #(
    parameter int unsigned FILL_BITS = 13
);
    logic                              enable;
    logic [FILL_BITS-1:0]              fifo_fill;
    logic                              fifo_empty;
    logic                              fifo_full;
    logic                              fifo_rd_en;
    logic                              dac_load;
    logic                              dac_mute;
    logic                              host_ready;
    logic                              underrun;
    logic [7:0]                        underrun_count;
    logic [playback_pkg::STATE_W-1:0]  state;

    modport master (
        input  enable, fifo_fill, fifo_empty, fifo_full,
        output fifo_rd_en, dac_load, dac_mute, host_ready,
               underrun, underrun_count, state
    );

    modport slave (
        output enable, fifo_fill, fifo_empty, fifo_full,
        input  fifo_rd_en, dac_load, dac_mute, host_ready,
               underrun, underrun_count, state
    );
endinterface

// File: rtl/playback_ctrl_sample_tick_gen.sv
// Sample-period divider: tick is high on the last cycle of each DIV-cycle period while run=1.
module sample_tick_gen #(
    parameter int unsigned DIV = 1088
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);
    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || !run) begin
            cnt <= RELOAD;
        end else if (cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    always_comb begin
        tick = run && (cnt == '0);
    end
endmodule

// File: rtl/playback_ctrl.sv
// Playback sequencer: prebuffer gate, per-sample FIFO reads, underrun recovery,
// hysteretic host flow control and a saturating underrun counter.
module playback_ctrl
    import playback_pkg::*;
#(
    parameter int unsigned FILL_BITS   = 13,
    parameter int unsigned SAMPLE_DIV  = 1088,
    parameter int unsigned START_LEVEL = 4096,
    parameter int unsigned LOW_LEVEL   = 819,
    parameter int unsigned HIGH_LEVEL  = 7373
) (
    input  logic             clk,
    input  logic             reset,
    playback_ctrl_if.master  bus
);
    localparam int unsigned FILL_W = FILL_BITS + 1;
    localparam logic [FILL_W-1:0] FULL_FILL = {1'b1, {FILL_BITS{1'b0}}};
    localparam logic [FILL_W-1:0] START_L   = FILL_W'(START_LEVEL);
    localparam logic [FILL_W-1:0] LOW_L     = FILL_W'(LOW_LEVEL);
    localparam logic [FILL_W-1:0] HIGH_L    = FILL_W'(HIGH_LEVEL);

    state_t            st;
    logic              tick;
    logic [FILL_W-1:0] fill_eff;
    logic              rd_en;
    logic              load;
    logic              mute;
    logic              ready;
    logic              urun;
    logic [7:0]        urun_cnt;

    // fifo_fill wraps to 0 when the FIFO is completely full
    always_comb begin
        fill_eff = bus.fifo_full ? FULL_FILL : {1'b0, bus.fifo_fill};
    end

    sample_tick_gen #(.DIV(SAMPLE_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .run   (st == ST_PLAY),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            st       <= ST_IDLE;
            mute     <= 1'b1;
            rd_en    <= 1'b0;
            load     <= 1'b0;
            urun     <= 1'b0;
            urun_cnt <= '0;
            ready    <= 1'b1;
        end else begin
            rd_en <= 1'b0;
            urun  <= 1'b0;
            load  <= rd_en;

            if (fill_eff >= HIGH_L) begin
                ready <= 1'b0;
            end else if (fill_eff <= LOW_L) begin
                ready <= 1'b1;
            end

            // disable wins over any transition and over a same-cycle tick
            if (!bus.enable) begin
                st   <= ST_IDLE;
                mute <= 1'b1;
            end else begin
                case (st)
                    ST_IDLE: begin
                        st   <= ST_PREFILL;
                        mute <= 1'b1;
                    end
                    ST_PREFILL: begin
                        if (fill_eff >= START_L) begin
                            st   <= ST_PLAY;
                            mute <= 1'b0;
                        end else begin
                            mute <= 1'b1;
                        end
                    end
                    ST_PLAY: begin
                        mute <= 1'b0;
                        if (tick) begin
                            if (bus.fifo_empty) begin
                                urun <= 1'b1;
                                st   <= ST_PREFILL;
                                mute <= 1'b1;
                                if (urun_cnt != 8'hFF) begin
                                    urun_cnt <= urun_cnt + 8'd1;
                                end
                            end else begin
                                rd_en <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        st   <= ST_IDLE;
                        mute <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.fifo_rd_en     = rd_en;
    assign bus.dac_load       = load;
    assign bus.dac_mute       = mute;
    assign bus.host_ready     = ready;
    assign bus.underrun       = urun;
    assign bus.underrun_count = urun_cnt;
    assign bus.state          = st;
endmodule

// File: tb/tb_playback_ctrl.sv
// Directed bench for playback_ctrl with a scaled-down FIFO (depth 64, 20 cycles per sample).
module tb_playback_ctrl;
    localparam int FB    = 6;
    localparam int DIV   = 20;
    localparam int START = 32;
    localparam int LOW   = 12;
    localparam int HIGH  = 57;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;

    playback_ctrl_if #(.FILL_BITS(FB)) bus ();

    playback_ctrl #(
        .FILL_BITS   (FB),
        .SAMPLE_DIV  (DIV),
        .START_LEVEL (START),
        .LOW_LEVEL   (LOW),
        .HIGH_LEVEL  (HIGH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_rd = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO occupancy model: one write per 16 cycles when wr_on, one read per DUT strobe
    int   count = 0;
    int   wr_div = 0;
    logic wr_on = 1'b0;
    logic set_req = 1'b0;
    int   set_val = 0;

    always @(posedge clk) begin
        wr_div <= (wr_div == 15) ? 0 : wr_div + 1;
        if (set_req)
            count <= set_val;
        else
            count <= count + ((wr_on && wr_div == 15 && count < DEPTH) ? 1 : 0)
                           - ((bus.fifo_rd_en && count > 0) ? 1 : 0);
    end

    assign bus.fifo_fill  = count[FB-1:0];
    assign bus.fifo_full  = (count == DEPTH);
    assign bus.fifo_empty = (count == 0);

    task automatic set_fill(input int v);
        @(negedge clk);
        set_val = v;
        set_req = 1'b1;
        @(negedge clk);
        set_req = 1'b0;
    endtask

    task automatic wait_rd(input int budget);
        int g = 0;
        while (bus.fifo_rd_en !== 1'b1 && g < budget) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (bus.fifo_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL wait_rd: no fifo_rd_en within %0d cycles", budget);
        end
        last_rd = cyc;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget);
        int g = 0;
        while (bus.state !== s && g < budget) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (bus.state !== s) begin
            errors++;
            $display("FAIL wait_state: state=%0d want %0d", bus.state, s);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.enable = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.state !== 2'd0 || bus.dac_mute !== 1'b1 || bus.fifo_rd_en !== 1'b0 ||
            bus.dac_load !== 1'b0 || bus.underrun !== 1'b0 || bus.underrun_count !== 8'd0 ||
            bus.host_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: st=%0d mute=%b rd=%b ld=%b ur=%b cnt=%0d hr=%b want 0 1 0 0 0 0 1",
                     bus.state, bus.dac_mute, bus.fifo_rd_en, bus.dac_load, bus.underrun,
                     bus.underrun_count, bus.host_ready);
        end
        reset = 1'b0;
    endtask

    task automatic test_prefill_play();
        int cyc_full = -1;
        int cyc_play = -1;
        int g = 0;
        wr_on = 1'b1;
        bus.enable = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.state !== 2'd1) begin
            errors++;
            $display("FAIL enter_prefill: state=%0d want 1", bus.state);
        end
        while (cyc_play < 0 && g < 3000) begin
            @(negedge clk);
            g++;
            if (bus.state === 2'd2) cyc_play = cyc;
            else begin
                checks++;
                if (bus.dac_mute !== 1'b1) begin
                    errors++;
                    $display("FAIL prefill_mute: dac_mute=%b want 1 at fill %0d", bus.dac_mute, count);
                end
            end
            if (count >= START && cyc_full < 0) cyc_full = cyc;
        end
        checks++;
        if (cyc_play < 0 || cyc_full < 0 || cyc_play != cyc_full + 1) begin
            errors++;
            $display("FAIL play_entry: play at %0d want %0d", cyc_play, cyc_full + 1);
        end
        checks++;
        if (bus.dac_mute !== 1'b0) begin
            errors++;
            $display("FAIL play_unmute: dac_mute=%b want 0", bus.dac_mute);
        end
        for (int n = 0; n < 3; n++) begin
            wait_rd(DIV + 5);
            checks++;
            if (cyc != cyc_play + (n + 1) * DIV) begin
                errors++;
                $display("FAIL rd_spacing%0d: rd at cycle %0d want %0d", n, cyc, cyc_play + (n + 1) * DIV);
            end
            checks++;
            if (bus.dac_load !== 1'b0) begin
                errors++;
                $display("FAIL load_early%0d: dac_load=%b want 0", n, bus.dac_load);
            end
            @(negedge clk);
            checks++;
            if (bus.dac_load !== 1'b1 || bus.fifo_rd_en !== 1'b0) begin
                errors++;
                $display("FAIL load_follow%0d: dac_load=%b rd=%b want 1 0", n, bus.dac_load, bus.fifo_rd_en);
            end
        end
    endtask

    task automatic test_underrun();
        int g = 0;
        wr_on = 1'b0;
        while (bus.underrun !== 1'b1 && g < 6000) begin
            @(negedge clk);
            g++;
            if (bus.fifo_rd_en === 1'b1) last_rd = cyc;
        end
        checks++;
        if (bus.underrun !== 1'b1) begin
            errors++;
            $display("FAIL underrun_seen: underrun never pulsed");
        end
        checks++;
        if (cyc != last_rd + DIV) begin
            errors++;
            $display("FAIL underrun_timing: at %0d want %0d", cyc, last_rd + DIV);
        end
        checks++;
        if (bus.fifo_rd_en !== 1'b0 || bus.state !== 2'd1 || bus.underrun_count !== 8'd1 ||
            bus.dac_mute !== 1'b1) begin
            errors++;
            $display("FAIL underrun_effect: rd=%b st=%0d cnt=%0d mute=%b want 0 1 1 1",
                     bus.fifo_rd_en, bus.state, bus.underrun_count, bus.dac_mute);
        end
        @(negedge clk);
        checks++;
        if (bus.underrun !== 1'b0) begin
            errors++;
            $display("FAIL underrun_pulse: underrun=%b want 0", bus.underrun);
        end
        wr_on = 1'b1;
        wait_state(2'd2, 1000);
        checks++;
        if (count != START) begin
            errors++;
            $display("FAIL resume_level: fill=%0d want %0d", count, START);
        end
    endtask

    task automatic test_enable_drop();
        wait_rd(DIV + 5);
        bus.enable = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.dac_load !== 1'b1 || bus.state !== 2'd0 || bus.dac_mute !== 1'b1) begin
            errors++;
            $display("FAIL pending_load: ld=%b st=%0d mute=%b want 1 0 1",
                     bus.dac_load, bus.state, bus.dac_mute);
        end
        bus.enable = 1'b1;
        wait_state(2'd2, 1000);
        wait_rd(DIV + 5);
        repeat (DIV - 1) @(negedge clk);
        bus.enable = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.fifo_rd_en !== 1'b0 || bus.state !== 2'd0 || bus.dac_mute !== 1'b1 ||
            bus.underrun !== 1'b0) begin
            errors++;
            $display("FAIL drop_on_tick: rd=%b st=%0d mute=%b ur=%b want 0 0 1 0",
                     bus.fifo_rd_en, bus.state, bus.dac_mute, bus.underrun);
        end
        @(negedge clk);
        checks++;
        if (bus.dac_load !== 1'b0) begin
            errors++;
            $display("FAIL drop_no_load: dac_load=%b want 0", bus.dac_load);
        end
    endtask

    task automatic test_hysteresis();
        logic exp_hr;
        wr_on = 1'b0;
        bus.enable = 1'b0;
        set_fill(0);
        @(negedge clk);
        for (int c = 1; c <= DEPTH; c++) begin
            set_fill(c);
            if (c == HIGH) begin
                checks++;
                if (bus.host_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL hr_fall_latency: host_ready=%b want 1", bus.host_ready);
                end
            end
            @(negedge clk);
            exp_hr = (c >= HIGH) ? 1'b0 : 1'b1;
            checks++;
            if (bus.host_ready !== exp_hr) begin
                errors++;
                $display("FAIL hr_rise_fill%0d: host_ready=%b want %b", c, bus.host_ready, exp_hr);
            end
        end
        for (int c = DEPTH - 1; c >= 0; c--) begin
            set_fill(c);
            if (c == LOW) begin
                checks++;
                if (bus.host_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL hr_rise_latency: host_ready=%b want 0", bus.host_ready);
                end
            end
            @(negedge clk);
            exp_hr = (c <= LOW) ? 1'b1 : 1'b0;
            checks++;
            if (bus.host_ready !== exp_hr) begin
                errors++;
                $display("FAIL hr_drain_fill%0d: host_ready=%b want %b", c, bus.host_ready, exp_hr);
            end
        end
    endtask

    task automatic test_saturation();
        int g;
        int exp_cnt;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wr_on = 1'b0;
        bus.enable = 1'b1;
        set_fill(0);
        for (int k = 1; k <= 300; k++) begin
            set_fill(START);
            set_fill(0);
            g = 0;
            while (bus.underrun !== 1'b1 && g < DIV + 10) begin
                @(negedge clk);
                g++;
            end
            exp_cnt = (k > 255) ? 255 : k;
            checks++;
            if (bus.underrun !== 1'b1 || bus.underrun_count !== 8'(exp_cnt)) begin
                errors++;
                $display("FAIL sat_count%0d: ur=%b count=%0d want 1 %0d",
                         k, bus.underrun, bus.underrun_count, exp_cnt);
            end
        end
    endtask

    task automatic test_reset_mid_play();
        wr_on = 1'b1;
        bus.enable = 1'b1;
        set_fill(40);
        wait_state(2'd2, 20);
        wait_rd(DIV + 5);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.state !== 2'd0 || bus.dac_mute !== 1'b1 || bus.fifo_rd_en !== 1'b0 ||
            bus.dac_load !== 1'b0 || bus.underrun !== 1'b0 || bus.underrun_count !== 8'd0 ||
            bus.host_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_play: st=%0d mute=%b rd=%b ld=%b ur=%b cnt=%0d hr=%b want 0 1 0 0 0 0 1",
                     bus.state, bus.dac_mute, bus.fifo_rd_en, bus.dac_load, bus.underrun,
                     bus.underrun_count, bus.host_ready);
        end
        repeat (DIV + 2) begin
            @(negedge clk);
            checks++;
            if (bus.fifo_rd_en !== 1'b0 || bus.dac_load !== 1'b0) begin
                errors++;
                $display("FAIL reset_quiet: rd=%b ld=%b want 0 0", bus.fifo_rd_en, bus.dac_load);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        bus.enable = 1'b0;
        test_reset();
        test_prefill_play();
        test_underrun();
        test_enable_drop();
        test_hysteresis();
        test_saturation();
        test_reset_mid_play();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
